gray_code_tracker: RTL
======================

Name: gray_code_tracker

Overview:
- Receiving end of the gray-code counter interface: samples a gray-coded count, decodes it to binary, and infers step direction from consecutive samples.
- Accumulates a signed position and flags illegal jumps, i.e. any transition other than ±1 in the binary domain.
- Sits downstream of a gray-code counter or encoder. Its outputs feed a position or diagnostics register.

Parameters:
- WIDTH, 3, gray/binary code width in bits; legal range is WIDTH >= 2.
- POS_WIDTH, 8, width of the two's-complement position accumulator.
- ERR_CNT_WIDTH, 4, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- gray_in  input  WIDTH  gray-coded sample.
- gray_valid  input  1  gray_in is sampled on this cycle.
- clr_err  input  1  synchronous clear of err_sticky and err_cnt.
- binary_out  output  WIDTH  registered binary decode of the last accepted sample.
- step  output  1  one-cycle pulse: a legal ±1 transition was accepted.
- dir  output  1  direction of the last legal step: 1 = up, 0 = down.
- pos  output  POS_WIDTH  signed position accumulator.
- locked  output  1  a reference sample is held; the block is in TRACK.
- err  output  1  one-cycle pulse: illegal transition detected.
- err_sticky  output  1  set by err, cleared only by clr_err or reset.
- err_cnt  output  ERR_CNT_WIDTH  saturating count of err pulses.

Behaviour:
- Reset (reset_n low, asynchronous):
  - binary_out = 0, step = 0, dir = 1, pos = 0, locked = 0.
  - err = 0, err_sticky = 0, err_cnt = 0.
  - state = ACQUIRE.
- Decode (combinational): b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i = WIDTH-2 down to 0.
- On each gray_valid cycle, delta = b_new - binary_out, taken modulo 2^WIDTH.
- Latency: every output reflects a sample one clock after the gray_valid cycle. With gray_valid low, everything holds and step/err are 0.
- State ACQUIRE (locked = 0):
  - On gray_valid: binary_out <= b_new, go to TRACK.
  - No step, no err; pos unchanged.
- State TRACK (locked = 1), on gray_valid:
  - delta == 0: no step, no err; outputs unchanged.
  - delta == 1: step = 1, dir <= 1, pos <= pos + 1, binary_out <= b_new.
  - delta == 2^WIDTH - 1: step = 1, dir <= 0, pos <= pos - 1, binary_out <= b_new.
  - Any other delta: err = 1, err_sticky <= 1, err_cnt <= err_cnt + 1 (saturating at all-ones).
    - binary_out, pos and dir unchanged; go to RESYNC.
- State RESYNC (locked = 0):
  - On gray_valid: binary_out <= b_new (new reference), go to TRACK.
  - No step, no err, pos unchanged.
- Wrap rules:
  - Code wrap (max → 0 counts as +1; 0 → max counts as −1) is a legal step.
  - pos wraps two's-complement modulo 2^POS_WIDTH with no saturation and no flag.
- clr_err:
  - Takes effect the next edge and clears err_sticky and err_cnt.
  - If an error is detected in the same cycle, the error wins: err_sticky = 1 and err_cnt = 1.
  - clr_err does not affect state or pos.
- Reset mid-operation: immediate return to reset values. The first valid sample after release re-acquires with no step.

Test Plan:
- Reset, then WIDTH=3, gray_valid every cycle with 000,001,011,010,110,111,101,100,000:
  - First sample acquires with locked rising and no step.
  - Then 8 step pulses, dir = 1, pos = 8, binary_out = 0, err_sticky = 0.
- From locked at binary 0, feed 100,101,111,110:
  - binary 7,6,5,4.
  - 4 step pulses, dir = 0, pos = −4 (0xFC).
- Hold the same code for 3 valid cycles, then toggle gray_valid low for 5 cycles:
  - step = 0 and err = 0 throughout; pos, binary_out and dir unchanged.
- Locked at 000, feed 011 (binary 2):
  - err pulses one cycle, err_cnt = 1, err_sticky = 1, locked = 0, pos unchanged.
  - Next sample 010 re-locks with no step.
  - Then 110 gives step with dir = 1 and pos + 1.
- Force 17 illegal jumps (re-acquiring between each):
  - err_cnt saturates at 15.
  - Assert clr_err together with an 18th illegal jump → err_cnt = 1, err_sticky = 1.
  - clr_err alone then → err_cnt = 0, err_sticky = 0.
- Assert reset_n low asynchronously mid-tracking at pos = 5:
  - All outputs go to reset values before the next edge.
  - After release, first valid sample gives locked = 1 with no step.

Source files
------------

// File: rtl/gray_code_tracker.sv
// gray_code_tracker: samples a gray-coded count, decodes it to binary and
// tracks a signed position from legal +/-1 steps. Any other jump is flagged,
// counted, and forces a resynchronisation on the next valid sample.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ACQUIRE | no reference sample yet; next valid sample becomes reference
// TRACK   | reference held; valid samples are classified as step/err
// RESYNC  | illegal jump seen; next valid sample becomes new reference
module gray_code_tracker #(
    parameter int WIDTH         = 3,
    parameter int POS_WIDTH     = 8,
    parameter int ERR_CNT_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         gray_in,
    input  logic                     gray_valid,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         binary_out,
    output logic                     step,
    output logic                     dir,
    output logic [POS_WIDTH-1:0]     pos,
    output logic                     locked,
    output logic                     err,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        RESYNC  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]         D_UP     = WIDTH'(1);
    localparam logic [WIDTH-1:0]         D_DN     = '1;
    localparam logic [POS_WIDTH-1:0]     POS_ONE  = POS_WIDTH'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE  = ERR_CNT_WIDTH'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t                     state, state_nxt;
    logic [WIDTH-1:0]           b_new, delta, bin_nxt;
    logic                       step_nxt, dir_nxt, err_nxt, sticky_nxt;
    logic [POS_WIDTH-1:0]       pos_nxt;
    logic [ERR_CNT_WIDTH-1:0]   cnt_nxt;

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        b_new = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b_new[i] = ^(gray_in >> i);
        end
    end

    // Modulo-2^WIDTH distance from the held reference to the new sample.
    assign delta  = b_new - binary_out;
    assign locked = (state == TRACK);

    // Next-state and next-output decision for the current sample.
    always_comb begin
        state_nxt  = state;
        bin_nxt    = binary_out;
        step_nxt   = 1'b0;
        dir_nxt    = dir;
        pos_nxt    = pos;
        err_nxt    = 1'b0;
        sticky_nxt = err_sticky;
        cnt_nxt    = err_cnt;

        // Clear first so a same-cycle error re-sets sticky and counts from zero.
        if (clr_err) begin
            sticky_nxt = 1'b0;
            cnt_nxt    = '0;
        end

        if (gray_valid) begin
            case (state)
                ACQUIRE, RESYNC: begin
                    bin_nxt   = b_new;
                    state_nxt = TRACK;
                end
                TRACK: begin
                    if (delta == D_UP) begin
                        step_nxt = 1'b1;
                        dir_nxt  = 1'b1;
                        pos_nxt  = pos + POS_ONE;
                        bin_nxt  = b_new;
                    end else if (delta == D_DN) begin
                        step_nxt = 1'b1;
                        dir_nxt  = 1'b0;
                        pos_nxt  = pos - POS_ONE;
                        bin_nxt  = b_new;
                    end else if (delta != '0) begin
                        err_nxt    = 1'b1;
                        sticky_nxt = 1'b1;
                        cnt_nxt    = (cnt_nxt == CNT_MAX) ? CNT_MAX : cnt_nxt + CNT_ONE;
                        state_nxt  = RESYNC;
                    end
                end
                default: state_nxt = ACQUIRE;
            endcase
        end
    end

    // State and registered outputs with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ACQUIRE;
            binary_out <= '0;
            step       <= 1'b0;
            dir        <= 1'b1;
            pos        <= '0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            binary_out <= bin_nxt;
            step       <= step_nxt;
            dir        <= dir_nxt;
            pos        <= pos_nxt;
            err        <= err_nxt;
            err_sticky <= sticky_nxt;
            err_cnt    <= cnt_nxt;
        end
    end

endmodule
